imem_boot_loader: RTL and testbench

// - Writer side of the instruction memory: fills instmem from a byte stream
//   (UART RX or bench) before the pipeline fetches.
// - Holds the core in reset via cpu_hold until a complete, checksum-valid image is written.
// - Sits beside instmem; the pipeline reads instmem, this block owns its write port.

---
 rtl/boot_pkg.sv | 19 +
 rtl/imem_boot_loader_if.sv | 24 ++
 rtl/boot_word_asm.sv | 37 +++
 rtl/imem_boot_loader.sv | 138 +++++++++++++
 tb/tb_imem_boot_loader.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader: frame field
// widths and the loader state encoding.
`timescale 1ns/1ps
package boot_pkg;

    localparam int CNT_W  = 16;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        HDR0 = 3'd0,
        HDR1 = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } boot_state_e;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instmem write port of the boot loader.
// master = stream source / memory observer, slave = the loader itself.
`timescale 1ns/1ps
interface imem_boot_loader_if;
    import boot_pkg::*;

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;
    logic              imem_we;
    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/boot_word_asm.sv
// Assembles little-endian 32-bit words from accepted stream bytes.
// word_valid/word are presented combinationally on the 4th byte so the
// parent can register the instmem write in the following cycle.
`timescale 1ns/1ps
module boot_word_asm
    import boot_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [1:0]        byte_cnt;
    logic [WORD_W-1:0] shreg;

    // Count bytes within a word and shift them in from the top, so the first byte lands in [7:0].
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt <= '0;
            shreg    <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            shreg    <= '0;
        end else if (byte_en) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= {byte_in, shreg[WORD_W-1:BYTE_W]};
        end
    end

    assign word_valid = byte_en && (byte_cnt == 2'd3);
    assign word       = {byte_in, shreg[WORD_W-1:BYTE_W]};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed image (count, words, XOR checksum), writes
// it into instmem and releases the core only after a valid checksum.
`timescale 1ns/1ps
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int          IMEM_WORDS     = 64,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    imem_boot_loader_if.slave    bus,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 error
);

    // The idle counter must be able to hold TIMEOUT_CYCLES itself (saturation value).
    localparam int IDLE_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  MAX_WORDS = CNT_W'(IMEM_WORDS);

    boot_state_e       state;
    logic [BYTE_W-1:0] cnt_l;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  word_idx;
    logic [BYTE_W-1:0] xor_acc;
    logic [IDLE_W-1:0] idle;

    logic              accept;
    logic              rearm;
    logic              idle_state;
    logic              timeout_hit;
    logic              go_err;
    logic [CNT_W-1:0]  hdr_count;
    logic              word_valid;
    logic [WORD_W-1:0] word;

    assign accept      = bus.in_valid && bus.in_ready;
    assign rearm       = start && (state == DONE || state == ERR);
    assign idle_state  = (state == HDR1) || (state == DATA) || (state == CSUM);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && idle_state && !accept && (idle == IDLE_LAST);
    assign hdr_count   = {bus.in_data, cnt_l};
    assign go_err      = timeout_hit
                       || (state == HDR1 && accept && hdr_count > MAX_WORDS)
                       || (state == CSUM && accept && bus.in_data != xor_acc);

    boot_word_asm u_word_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (rearm),
        .byte_en    (accept && state == DATA),
        .byte_in    (bus.in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Loader FSM with word index, running XOR, idle counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= HDR0;
            bus.in_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= BASE_ADDR;
            bus.imem_wdata <= '0;
            cpu_hold       <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            cnt_l          <= '0;
            word_cnt       <= '0;
            word_idx       <= '0;
            xor_acc        <= '0;
            idle           <= '0;
        end else begin
            bus.imem_we  <= 1'b0;
            bus.in_ready <= (state != DONE) && (state != ERR);

            if (accept) begin
                idle <= '0;
            end else if (idle_state && idle != IDLE_MAX) begin
                idle <= idle + 1'b1;
            end

            if (accept && state != CSUM) begin
                xor_acc <= xor_acc ^ bus.in_data;
            end

            if (word_valid) begin
                bus.imem_we    <= 1'b1;
                bus.imem_wdata <= word;
                bus.imem_addr  <= BASE_ADDR + 32'({word_idx, 2'b00});
                word_idx       <= word_idx + 1'b1;
            end

            if (go_err) begin
                state        <= ERR;
                error        <= 1'b1;
                cpu_hold     <= 1'b1;
                bus.in_ready <= 1'b0;
            end else begin
                case (state)
                    HDR0: if (accept) begin
                        cnt_l <= bus.in_data;
                        state <= HDR1;
                    end
                    HDR1: if (accept) begin
                        word_cnt <= hdr_count;
                        state    <= (hdr_count == '0) ? CSUM : DATA;
                    end
                    DATA: if (word_valid && word_idx == word_cnt - 1'b1) begin
                        state <= CSUM;
                    end
                    CSUM: if (accept) begin
                        state        <= DONE;
                        done         <= 1'b1;
                        cpu_hold     <= 1'b0;
                        bus.in_ready <= 1'b0;
                    end
                    DONE, ERR: if (start) begin
                        state        <= HDR0;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        word_idx     <= '0;
                        xor_acc      <= '0;
                        idle         <= '0;
                        bus.in_ready <= 1'b1;
                    end
                    default: state <= HDR0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: framed images, checksum and size
// errors, timeout, re-arm via start and reset in the middle of a frame.
`timescale 1ns/1ps
module tb_imem_boot_loader;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic cpu_hold;
    logic done;
    logic error;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  frame_q[$];

    imem_boot_loader_if bus();

    imem_boot_loader #(
        .IMEM_WORDS     (64),
        .BASE_ADDR      (32'h0),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus.slave),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Record every instmem write strobe mid-cycle.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr_q.push_back(bus.imem_addr);
            wr_data_q.push_back(bus.imem_wdata);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && t < 20) begin
            tick(1);
            t++;
        end
        if (t >= 20) check_val("send_ready_wait", 32'(bus.in_ready), 32'd1);
        tick(1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int max_gap);
        foreach (frame_q[i]) begin
            if (max_gap > 0) tick(int'($urandom_range(max_gap, 0)));
            send_byte(frame_q[i]);
        end
    endtask

    task automatic check_write(input string tag, input int idx, input logic [31:0] addr, input logic [31:0] data);
        if (idx < wr_addr_q.size()) begin
            check_val({tag, "_addr"}, wr_addr_q[idx], addr);
            check_val({tag, "_data"}, wr_data_q[idx], data);
        end else begin
            check_val({tag, "_missing"}, 32'(wr_addr_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state
        tick(3);
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_val("rst_imem_we", 32'(bus.imem_we), 32'd0);
        check_val("rst_imem_addr", bus.imem_addr, 32'h0);
        check_val("rst_imem_wdata", bus.imem_wdata, 32'h0);
        check_val("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_error", 32'(error), 32'd0);
        reset = 1'b1;
        check_val("rdy_first_cycle", 32'(bus.in_ready), 32'd0);
        tick(1);
        check_val("rdy_after_release", 32'(bus.in_ready), 32'd1);

        // N=2 good frame, write latency checked after each 4th data byte
        clear_writes();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check_val("a_w0_we", 32'(bus.imem_we), 32'd1);
        check_val("a_w0_addr", bus.imem_addr, 32'h0);
        check_val("a_w0_data", bus.imem_wdata, 32'h0000_0013);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        check_val("a_w1_we", 32'(bus.imem_we), 32'd1);
        check_val("a_w1_addr", bus.imem_addr, 32'h4);
        check_val("a_w1_data", bus.imem_wdata, 32'h0010_0093);
        send_byte(8'h92);
        check_val("a_done", 32'(done), 32'd1);
        check_val("a_cpu_hold", 32'(cpu_hold), 32'd0);
        check_val("a_error", 32'(error), 32'd0);
        check_val("a_in_ready", 32'(bus.in_ready), 32'd0);
        check_val("a_nwrites", 32'(wr_addr_q.size()), 32'd2);
        check_write("a_wr0", 0, 32'h0, 32'h0000_0013);
        check_write("a_wr1", 1, 32'h4, 32'h0010_0093);

        // start together with in_valid in DONE: byte 0x55 must not be consumed
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        bus.in_valid = 1'b0;
        check_val("rearm_done", 32'(done), 32'd0);
        check_val("rearm_cpu_hold", 32'(cpu_hold), 32'd1);
        check_val("rearm_in_ready", 32'(bus.in_ready), 32'd1);

        // N=0 frame: 00 00 00
        clear_writes();
        frame_q = '{8'h00, 8'h00, 8'h00};
        send_frame(0);
        check_val("n0_done", 32'(done), 32'd1);
        check_val("n0_error", 32'(error), 32'd0);
        check_val("n0_nwrites", 32'(wr_addr_q.size()), 32'd0);
        pulse_start();

        // Bad checksum
        clear_writes();
        frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
        send_frame(0);
        check_val("b_error", 32'(error), 32'd1);
        check_val("b_cpu_hold", 32'(cpu_hold), 32'd1);
        check_val("b_done", 32'(done), 32'd0);
        check_val("b_in_ready", 32'(bus.in_ready), 32'd0);
        tick(3);
        check_val("b_nwrites", 32'(wr_addr_q.size()), 32'd2);
        pulse_start();
        check_val("b_rearm_error", 32'(error), 32'd0);
        check_val("b_rearm_in_ready", 32'(bus.in_ready), 32'd1);
        check_val("b_rearm_cpu_hold", 32'(cpu_hold), 32'd1);

        // Oversized image: N=65
        clear_writes();
        send_byte(8'h41); send_byte(8'h00);
        check_val("big_error", 32'(error), 32'd1);
        check_val("big_in_ready", 32'(bus.in_ready), 32'd0);
        tick(3);
        check_val("big_nwrites", 32'(wr_addr_q.size()), 32'd0);
        pulse_start();

        // Good frame with random in_valid gaps of 0..5 cycles
        clear_writes();
        frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
        send_frame(5);
        check_val("gap_done", 32'(done), 32'd1);
        check_val("gap_nwrites", 32'(wr_addr_q.size()), 32'd2);
        check_write("gap_wr0", 0, 32'h0, 32'h0000_0013);
        check_write("gap_wr1", 1, 32'h4, 32'h0010_0093);
        pulse_start();

        // HDR0 never times out
        tick(40);
        check_val("hdr0_no_timeout", 32'(error), 32'd0);

        // Timeout 16 cycles after the last accepted byte
        clear_writes();
        frame_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
        send_frame(0);
        tick(15);
        check_val("to_before", 32'(error), 32'd0);
        tick(1);
        check_val("to_at16", 32'(error), 32'd1);
        check_val("to_cpu_hold", 32'(cpu_hold), 32'd1);
        check_val("to_nwrites", 32'(wr_addr_q.size()), 32'd0);
        pulse_start();

        // Reset in the middle of DATA, then a fresh N=1 frame
        frame_q = '{8'h02, 8'h00, 8'h13, 8'h00};
        send_frame(0);
        reset = 1'b0;
        tick(1);
        check_val("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_val("mid_rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check_val("mid_rst_addr", bus.imem_addr, 32'h0);
        tick(1);
        reset = 1'b1;
        clear_writes();
        frame_q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
        send_frame(0);
        check_val("f_done", 32'(done), 32'd1);
        check_val("f_cpu_hold", 32'(cpu_hold), 32'd0);
        check_val("f_nwrites", 32'(wr_addr_q.size()), 32'd1);
        check_write("f_wr0", 0, 32'h0, 32'h1234_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
